// File: rtl/puf_response_controller.sv
// Sequences an RO PUF bit cell through clear/measure/hold windows per challenge
// and assembles the sampled comparator bits into one atomically published word.
module puf_response_controller #(
    parameter int RESP_BITS     = 16,
    parameter int WINDOW_CYCLES = 1024,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [7:0]           seed_challenge,
    input  logic                 puf_out,
    output logic                 puf_en,
    output logic                 puf_reset,
    output logic [7:0]           puf_challenge,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] response
);

    localparam int KW   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam int MAXC = (WINDOW_CYCLES > SETTLE_CYCLES) ?
                          WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int TW   = (MAXC > 2) ? $clog2(MAXC) : 1;

    localparam logic [TW-1:0] SET_LAST  = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] WIN_LAST  = TW'(WINDOW_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(1);
    localparam logic [KW-1:0] K_LAST    = KW'(RESP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MEASURE,
        HOLD,
        DONE
    } state_t;

    state_t                 state;
    logic [TW-1:0]          timer;
    logic [KW-1:0]          idx;
    logic [7:0]             seed;
    logic [RESP_BITS-1:0]   shreg;
    logic [RESP_BITS-1:0]   shreg_nxt;
    logic [7:0]             chal_nxt;

    // Word including the bit captured at the end of the current HOLD
    always_comb begin
        shreg_nxt      = shreg;
        shreg_nxt[idx] = puf_out;
    end

    assign chal_nxt = seed + 8'(idx) + 8'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            timer         <= '0;
            idx           <= '0;
            seed          <= '0;
            shreg         <= '0;
            puf_en        <= 1'b0;
            puf_reset     <= 1'b1;
            puf_challenge <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            response      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        seed          <= seed_challenge;
                        idx           <= '0;
                        timer         <= '0;
                        puf_challenge <= seed_challenge;
                        puf_en        <= 1'b1;
                        puf_reset     <= 1'b1;
                        busy          <= 1'b1;
                        state         <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (abort) begin
                        state     <= IDLE;
                        timer     <= '0;
                        puf_en    <= 1'b0;
                        puf_reset <= 1'b1;
                        busy      <= 1'b0;
                    end else if (timer == SET_LAST) begin
                        timer     <= '0;
                        puf_reset <= 1'b0;
                        state     <= MEASURE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                MEASURE: begin
                    if (abort) begin
                        state     <= IDLE;
                        timer     <= '0;
                        puf_en    <= 1'b0;
                        puf_reset <= 1'b1;
                        busy      <= 1'b0;
                    end else if (timer == WIN_LAST) begin
                        timer  <= '0;
                        puf_en <= 1'b0;
                        state  <= HOLD;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                HOLD: begin
                    if (abort) begin
                        state     <= IDLE;
                        timer     <= '0;
                        puf_en    <= 1'b0;
                        puf_reset <= 1'b1;
                        busy      <= 1'b0;
                    end else if (timer == HOLD_LAST) begin
                        timer <= '0;
                        shreg <= shreg_nxt;
                        if (idx == K_LAST) begin
                            response  <= shreg_nxt;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            puf_reset <= 1'b1;
                            state     <= DONE;
                        end else begin
                            idx           <= idx + 1'b1;
                            puf_challenge <= chal_nxt;
                            puf_en        <= 1'b1;
                            puf_reset     <= 1'b1;
                            state         <= CLEAR;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    puf_en    <= 1'b0;
                    puf_reset <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_response_controller.sv
// Bench for puf_response_controller: vector table of full runs plus
// abort, restart-spam and mid-run reset sequences, with a response scoreboard.
module tb_puf_response_controller;

    localparam int RB = 4;
    localparam int W  = 8;
    localparam int S  = 2;
    localparam int PB = S + W + 2;
    localparam int ND = RB * PB + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [7:0]    seed;
    logic          puf_out;
    logic          puf_en;
    logic          puf_reset;
    logic [7:0]    puf_challenge;
    logic          busy;
    logic          done;
    logic [RB-1:0] response;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         mode  = 0;
    logic       tog   = 1'b0;
    logic [3:0] cur_resp = 4'h0;
    logic [3:0] sb[$];

    typedef struct {
        logic [7:0] sd;
        int         md;
        logic [3:0] want;
    } vec_t;

    vec_t tbl[4];

    always #5 clk = ~clk;

    puf_response_controller #(
        .RESP_BITS    (RB),
        .WINDOW_CYCLES(W),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .seed_challenge(seed),
        .puf_out       (puf_out),
        .puf_en        (puf_en),
        .puf_reset     (puf_reset),
        .puf_challenge (puf_challenge),
        .busy          (busy),
        .done          (done),
        .response      (response)
    );

    always @(posedge clk) tog <= ~tog;

    // Mode 1 toggles every cycle except the capture cycle, where it is held at 1
    always_comb begin
        if (mode == 0)
            puf_out = puf_challenge[0];
        else if (cyc >= 1 && cyc < ND && ((cyc - 1) % PB) == PB - 1)
            puf_out = 1'b1;
        else
            puf_out = tog;
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra_done cyc=%0d got=done want=none", cyc);
            end else begin
                chk("sb_resp", 32'(response), 32'(sb.pop_front()));
            end
        end
    end

    task automatic do_run(input logic [7:0] sd, input int md,
                          input logic [3:0] want, input int ab_c,
                          input int rs_c, input bit spam, input bit ab0);
        bit         full;
        bit         live;
        int         b;
        int         p;
        logic [3:0] st_exp;
        logic [7:0] ce;
        full = (ab_c == 0) && (rs_c == 0);
        mode = md;
        @(posedge clk);
        #1;
        cyc   = 0;
        start = 1'b1;
        abort = ab0;
        seed  = sd;
        if (full) sb.push_back(want);
        for (int c = 1; c <= ND + 5; c++) begin
            @(posedge clk);
            #1;
            cyc   = c;
            start = spam && (c <= ND - 2) && (c % 2 == 1);
            abort = (c == ab_c);
            if (rs_c != 0 && c == rs_c) reset = 1'b0;
            if (rs_c != 0 && c == rs_c + 3) reset = 1'b1;
            @(negedge clk);
            live = (ab_c == 0 || c <= ab_c) && (rs_c == 0 || c < rs_c);
            if (rs_c != 0 && c == rs_c) cur_resp = 4'h0;
            if (live && c == ND) cur_resp = want;
            b = (c - 1) / PB;
            p = (c - 1) % PB;
            if (live && c < ND) begin
                if (p < S) st_exp = 4'b1110;
                else if (p < S + W) st_exp = 4'b1010;
                else st_exp = 4'b0010;
                ce = sd + 8'(b);
                chk("challenge", 32'(puf_challenge), 32'(ce));
            end else if (live && c == ND) begin
                st_exp = 4'b0101;
            end else begin
                st_exp = 4'b0100;
            end
            chk("en_rst_busy_done", 32'({puf_en, puf_reset, busy, done}),
                32'(st_exp));
            chk("response", 32'(response), 32'(cur_resp));
            if (rs_c != 0 && c >= rs_c && c < rs_c + 3)
                chk("reset_challenge", 32'(puf_challenge), 32'h0);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        tbl[0] = '{sd: 8'h10, md: 0, want: 4'b1010};
        tbl[1] = '{sd: 8'hFE, md: 0, want: 4'b1010};
        tbl[2] = '{sd: 8'h10, md: 1, want: 4'b1111};
        tbl[3] = '{sd: 8'h55, md: 0, want: 4'b0101};

        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        seed  = 8'h00;
        @(negedge clk);
        chk("reset_stat", 32'({puf_en, puf_reset, busy, done}), 32'h4);
        chk("reset_chal", 32'(puf_challenge), 32'h0);
        chk("reset_resp", 32'(response), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("idle_stat", 32'({puf_en, puf_reset, busy, done}), 32'h4);

        for (int i = 0; i < 4; i++)
            do_run(tbl[i].sd, tbl[i].md, tbl[i].want, 0, 0, 1'b0, 1'b0);

        // start and abort together in IDLE: start wins
        do_run(8'h10, 0, 4'hA, 0, 0, 1'b0, 1'b1);
        // abort in MEASURE of bit 2; response keeps 0xA
        do_run(8'h55, 0, 4'h5, 2 * PB + S + 3, 0, 1'b0, 1'b0);
        do_run(8'h55, 0, 4'h5, 0, 0, 1'b0, 1'b0);
        // repeated start while busy
        do_run(8'hFE, 0, 4'hA, 0, 0, 1'b1, 1'b0);
        // reset mid-run
        do_run(8'h10, 0, 4'hA, 0, 20, 1'b0, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/puf_response_controller.md
Name: puf_response_controller

Overview:
- Sequencer that drives a single-bit RO PUF stage (ring oscillator enable, counter clear, 8-bit challenge) and consumes its 1-bit comparator output.
- Issues RESP_BITS consecutive challenges derived from a seed, runs one timed measurement window per challenge, and assembles the sampled bits into an RESP_BITS-wide response word.
- Publishes the word atomically with a one-cycle done pulse.
- Sits directly downstream of the PUF bit cell and upstream of key/ID consumers.

Parameters:
- RESP_BITS, 16, number of response bits per run (1..256).
- WINDOW_CYCLES, 1024, clk cycles the ROs count per bit (>=1).
- SETTLE_CYCLES, 4, clk cycles the PUF counters are held in clear per bit (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- abort  input  1  synchronous; cancel a run in progress.
- seed_challenge  input  8  base challenge, latched on accepted start.
- puf_out  input  1  PUF comparator result (count_1 vs count_2).
- puf_en  output  1  ring oscillator enable to the PUF.
- puf_reset  output  1  active-high synchronous clear to the PUF counters.
- puf_challenge  output  8  challenge to the PUF (bits 7:4 select bank 1, bits 3:0 select bank 2).
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse; response valid.
- response  output  RESP_BITS  last completed response word.

Behaviour:
- Reset (reset=0, async): state=IDLE. puf_en=0, puf_reset=1, puf_challenge=0, busy=0, done=0, response=0. Bit index, timer, seed latch and shift register all cleared.
- Challenge for bit k is (seed + k) mod 256. Wraps at 255 to 0 with no flag.
- Internal bit index width is clog2(RESP_BITS), minimum 1.
- IDLE: puf_en=0, puf_reset=1, busy=0.
  - If start=1: latch seed, k=0, go to CLEAR.
  - start and abort high together in IDLE: start wins.
- CLEAR: lasts exactly SETTLE_CYCLES cycles.
  - puf_en=1, puf_reset=1, puf_challenge=challenge(k), busy=1.
  - The challenge is stable from the first CLEAR cycle through the end of HOLD.
- MEASURE: lasts exactly WINDOW_CYCLES cycles. puf_en=1, puf_reset=0.
- HOLD: lasts exactly 2 cycles. puf_en=0, puf_reset=0 (counters frozen, comparator settles).
  - puf_out is captured into shift-register bit k at the rising edge ending the second HOLD cycle.
  - Then: if k==RESP_BITS-1 go to DONE; else k=k+1 and go to CLEAR.
- DONE: lasts 1 cycle.
  - response <= shift register (bit k of response = bit measured with challenge(k)).
  - done=1, busy=0, puf_en=0, puf_reset=1. Then go to IDLE.
- Latency: per bit = SETTLE_CYCLES+WINDOW_CYCLES+2 cycles. done is high in cycle N = RESP_BITS*(SETTLE_CYCLES+WINDOW_CYCLES+2)+1, counting the cycle start is sampled as cycle 0.
- response changes only in DONE. It holds its value across later runs, aborts and start pulses until the next DONE; async reset clears it.
- start while busy: ignored, no restart, no queuing.
- abort=1 in CLEAR/MEASURE/HOLD: next state is IDLE.
  - Partial bits are discarded; response unchanged; done not asserted.
  - puf_en=0 and puf_reset=1 from the next cycle.
- abort in DONE: ignored (done still pulses).
- Reset asserted mid-run: immediate return to reset values, including response=0.
- Timer and index are never allowed to overflow: the comparison is made on terminal count, not wrap.
- puf_out is used only in the second HOLD cycle. Its value in all other cycles has no effect.

Test Plan:
- Params RESP_BITS=4, WINDOW_CYCLES=8, SETTLE_CYCLES=2. PUF model returns puf_out = challenge[0]; seed=0x10 -> challenges 0x10,0x11,0x12,0x13; done exactly 49 cycles after start; response=4'b1010; busy high cycles 1..48.
- Seed=0xFE, same params -> challenges 0xFE,0xFF,0x00,0x01 (wrap); puf_out=challenge[0] gives response=4'b1010; the bench checks puf_challenge during each CLEAR.
- Waveform check per bit: puf_reset=1 for exactly 2 cycles, then puf_en=1 with puf_reset=0 for 8 cycles, then puf_en=0 for 2 cycles. puf_out toggled every cycle outside the second HOLD cycle, held at 1 in it -> response=4'b1111.
- Complete a run with response=0xA. Start again, assert abort during MEASURE of bit 2 -> IDLE the next cycle, no done, response stays 0xA; a further start runs to completion normally.
- start pulsed repeatedly while busy -> single done at cycle 49. reset driven low at cycle 20 of a run -> all outputs at reset values immediately, response=0, no done after release.
- start and abort high together in IDLE -> run accepted (busy=1 the next cycle).
